vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the pixel-stream interface: generates hcount/vcount, hsync/vsync and
//  hblnk/vblnk for the overlay stages (e.g. rectangle/background drawers) downstream.
//  Free-running raster counters on pclk; all outputs are registered and mutually
//  consistent in every cycle. Adds frame/line start strobes and a stall enable.
// PARAMETERS
//  H_VISIBLE   800   active pixels per line
//  H_FP        40    horizontal front porch (pixels)
//  H_SYNC      128   hsync pulse width (pixels)
//  H_BP        88    horizontal back porch (pixels)
//  V_VISIBLE   600   active lines per frame
//  V_FP        1     vertical front porch (lines)
//  V_SYNC      4     vsync pulse width (lines)
//  V_BP        23    vertical back porch (lines)
//  SYNC_POL    1     1 = sync active high, 0 = active low (applies to both syncs)
// PORTS
//  pclk         in   1   pixel clock; all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  en           in   1   1 = advance raster each cycle; 0 = hold every output
//  hcount       out  11  pixel index in line, 0..H_TOTAL-1
//  vcount       out  11  line index in frame, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync (polarity per SYNC_POL)
//  vsync        out  1   vertical sync (polarity per SYNC_POL)
//  hblnk        out  1   1 when hcount >= H_VISIBLE
//  vblnk        out  1   1 when vcount >= V_VISIBLE
//  line_start   out  1   1-cycle strobe while hcount==0 (after first advance)
//  frame_start  out  1   1-cycle strobe while hcount==0 && vcount==0 (after first advance)
// BEHAVIOUR
//  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1056); V_TOTAL likewise (628). Totals must be
//    <= 2048; counters are 11-bit unsigned, compares use full 11-bit width.
//  - Reset (async assert, sync-to-pclk release by system): hcount=0, vcount=0,
//    hblnk=0, vblnk=0, line_start=0, frame_start=0, hsync=vsync=inactive (~SYNC_POL).
//  - Per pclk edge with en=1: hcount<=hcount+1; at hcount==H_TOTAL-1 wrap to 0 and
//    vcount<=vcount+1; at hcount==H_TOTAL-1 && vcount==V_TOTAL-1 both wrap to 0.
//  - en=0: every output, incl. strobes, holds its value (strobe may stay high >1 cycle
//    only while stalled). en takes effect on the same edge it is sampled.
//  - Flags are computed from the NEXT count values and registered with the counts:
//    zero latency between a count value and its flags on the output bus.
//  - hblnk = (hcount >= H_VISIBLE); hsync active iff
//    H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (840..967).
//  - vblnk = (vcount >= V_VISIBLE); vsync active iff
//    V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (601..604), whole lines,
//    changing only at hcount==0.
//  - line_start/frame_start are 0 in the reset state (0,0) and asserted on every
//    later arrival at hcount==0 / (0,0).
//  - Reset mid-line/mid-sync: outputs go to reset values immediately (async);
//    raster restarts from (0,0), no partial sync pulse is completed.
// TESTING
//  1. rst high 3 cycles then low, en=1 -> reset values during rst; first edge after
//     release gives hcount=1,vcount=0, hblnk=0, hsync inactive, strobes 0.
//  2. Run one line -> hblnk rises at hcount=800; hsync active 840..967 (128 cycles);
//     hcount 1055 -> 0 with vcount 0 -> 1 and line_start=1 for exactly 1 cycle.
//  3. Run full frame -> vblnk rises at vcount=600 hcount=0; vsync active 601..604
//     (4*1056 = 4224 cycles); wrap (1055,627)->(0,0) with frame_start=1; period
//     663168 cycles.
//  4. Drop en for 10 cycles at hcount=967 (last hsync pixel) -> all outputs frozen,
//     hsync still active; on en=1 next edge hcount=968, hsync inactive.
//  5. Assert rst at (900,602) -> outputs zero/inactive asynchronously before next
//     pclk edge; after release raster restarts at (1,0).
//  6. SYNC_POL=0 build -> hsync/vsync idle high, low during 840..967 / 601..604;
//     reset value high.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Pixel-stream timing bus between the raster timing source and
//                the overlay stages downstream.
//                  en           stall control (1 = advance, 0 = hold)
//                  hcount       pixel index in line
//                  vcount       line index in frame
//                  hsync/vsync  sync pulses, polarity set by the source
//                  hblnk/vblnk  blanking flags
//                  line_start   strobe on arrival at hcount == 0
//                  frame_start  strobe on arrival at (0,0)
//                master = timing source, slave = consumer / stall controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic        en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        line_start;
    logic        frame_start;

    modport master (
        input  en,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
    );

    modport slave (
        output en,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Free-running VGA raster timing source. Produces hcount and
//                vcount, hsync/vsync, hblnk/vblnk and line/frame start strobes
//                on the pixel clock. All outputs are registered together so a
//                count value and its flags always appear in the same cycle.
//  Ports       : pclk - pixel clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - vga_timing_gen_if master (en in, timing bus out)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit SYNC_POL  = 1'b1
) (
    input  wire logic           pclk,
    input  wire logic           rst,
    vga_timing_gen_if.master    bus
);

    // Line and frame totals must not exceed 2048 so they fit the 11-bit counters.
    localparam logic [10:0] c_h_last     = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_v_last     = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_h_visible  = 11'(H_VISIBLE);
    localparam logic [10:0] c_v_visible  = 11'(V_VISIBLE);
    localparam logic [10:0] c_hs_start   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] c_vs_start   = 11'(V_VISIBLE + V_FP);
    // Sync end bounds are one bit wider: a sync pulse running to the very end
    // of a 2048-wide line would otherwise wrap its exclusive bound to zero.
    localparam logic [11:0] c_hs_end     = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [11:0] c_vs_end     = 12'(V_VISIBLE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_line_start;
    logic        r_frame_start;

    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic        w_hsync_act;
    logic        w_vsync_act;

    // Next raster position; flags below are derived from it so that they are
    // registered in the same edge as the count they describe.
    always_comb begin
        w_hcount_nxt = r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (r_hcount == c_h_last) begin
            w_hcount_nxt = 11'd0;
            if (r_vcount == c_v_last) begin
                w_vcount_nxt = 11'd0;
            end else begin
                w_vcount_nxt = r_vcount + 11'd1;
            end
        end
    end

    // vcount only moves at the line wrap, so vsync naturally changes at hcount==0.
    always_comb begin
        w_hsync_act = (w_hcount_nxt >= c_hs_start) && ({1'b0, w_hcount_nxt} < c_hs_end);
        w_vsync_act = (w_vcount_nxt >= c_vs_start) && ({1'b0, w_vcount_nxt} < c_vs_end);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (bus.en) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
            r_hblnk       <= (w_hcount_nxt >= c_h_visible);
            r_vblnk       <= (w_vcount_nxt >= c_v_visible);
            // Strobes mark arrival at line/frame origin; the reset state (0,0)
            // is not an arrival, hence they reset low. While stalled they hold.
            r_line_start  <= (w_hcount_nxt == 11'd0);
            r_frame_start <= (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
        end
    end

    assign bus.hcount      = r_hcount;
    assign bus.vcount      = r_vcount;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.hblnk       = r_hblnk;
    assign bus.vblnk       = r_vblnk;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
